multicycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the rv32i core. It steps each instruction through fetch, decode, execute, optional memory access and writeback over a single shared instruction/data memory port. It also arbitrates that port between instruction fetch and load/store. It sits beside the combinational control unit: it takes the decoded opcode and the already flag-gated decoder outputs, and produces one-cycle-qualified write and enable strobes for PC, IR, load-data register, register file and CSR file.

---
 rtl/multicycle_sequencer.sv | 154 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Steps each rv32i instruction through FETCH, DECODE, EXEC, optional MEM and
// WB over one shared instruction/data memory port. It also produces
// single-cycle write/enable strobes for PC, IR, MDR, register file and CSRs.
//
// Ports
//   clk, rst_n    : clock, synchronous active-low reset
//   op_code       : opcode field of the instruction register
//   dec_reg_w     : decoder register-write request
//   dec_csr_w     : decoder CSR-write request
//   dec_jump      : decoder jump selector (already masked for CSR ops)
//   dec_branch    : decoder branch-taken (branch AND ALU flag)
//   mem_ack       : memory completes the current request this cycle
//   mem_req       : memory request, held until acked
//   mem_we        : store request, meaningful only with mem_req
//   mem_addr_s    : address select, 0 = PC, 1 = ALU result
//   ir_en, md_en  : load IR / memory-data register
//   pc_en, pc_src : PC update strobe and next-PC select
//   reg_w_en      : register file write strobe
//   csr_w_en      : CSR write strobe
//   illegal_op    : one-cycle pulse in DECODE for an unrecognised opcode
//   retired       : one-cycle pulse in WB
//   state         : current FSM state, for debug
//
// Memory handshake: a transfer completes on a rising edge where mem_req and
// mem_ack are both 1. mem_req is held with mem_we/mem_addr_s stable until that
// edge; mem_ack while mem_req is 0 is ignored. A reset may withdraw mem_req
// without an ack, abandoning the access.
module multicycle_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_code,
  input  logic       dec_reg_w,
  input  logic       dec_csr_w,
  input  logic [1:0] dec_jump,
  input  logic       dec_branch,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_s,
  output logic       ir_en,
  output logic       md_en,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_w_en,
  output logic       csr_w_en,
  output logic       illegal_op,
  output logic       retired,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   op_legal;
  logic   is_load;
  logic   is_store;

  assign is_load  = (op_code == 7'b0000011);
  assign is_store = (op_code == 7'b0100011);

  always_comb begin
    op_legal = 1'b0;
    case (op_code)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011:
        op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr_s = 1'b0;
    ir_en      = 1'b0;
    md_en      = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    reg_w_en   = 1'b0;
    csr_w_en   = 1'b0;
    illegal_op = 1'b0;
    retired    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        ir_en   = mem_ack;
        if (mem_ack) state_d = S_DECODE;
      end

      S_DECODE: begin
        // The flag is latched here so the later states see a stable verdict
        // for the whole instruction.
        illegal_d  = ~op_legal;
        illegal_op = ~op_legal;
        state_d    = S_EXEC;
      end

      S_EXEC: begin
        if ((is_load || is_store) && !illegal_q) state_d = S_MEM;
        else                                     state_d = S_WB;
      end

      S_MEM: begin
        mem_req    = 1'b1;
        mem_addr_s = 1'b1;
        mem_we     = is_store;
        md_en      = mem_ack & is_load;
        if (mem_ack) state_d = S_WB;
      end

      S_WB: begin
        pc_en   = 1'b1;
        retired = 1'b1;
        // Illegal instructions retire as a NOP: sequential PC, no writes.
        if (!illegal_q) begin
          if (dec_jump != 2'b00) pc_src = dec_jump;
          else if (dec_branch)   pc_src = 2'b01;
          reg_w_en = dec_reg_w;
          csr_w_en = dec_csr_w;
        end
        state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op_code = 7'd0;
  logic       dec_reg_w = 1'b0;
  logic       dec_csr_w = 1'b0;
  logic [1:0] dec_jump = 2'b00;
  logic       dec_branch = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, mem_addr_s, ir_en, md_en, pc_en;
  logic [1:0] pc_src;
  logic       reg_w_en, csr_w_en, illegal_op, retired;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  string ctx = "";

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_code    (op_code),
    .dec_reg_w  (dec_reg_w),
    .dec_csr_w  (dec_csr_w),
    .dec_jump   (dec_jump),
    .dec_branch (dec_branch),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr_s (mem_addr_s),
    .ir_en      (ir_en),
    .md_en      (md_en),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .reg_w_en   (reg_w_en),
    .csr_w_en   (csr_w_en),
    .illegal_op (illegal_op),
    .retired    (retired),
    .state      (state)
  );

  typedef struct {
    logic [6:0] op;
    logic       rw;
    logic       cw;
    logic [1:0] jmp;
    logic       br;
    int         fw;       // wait cycles before fetch ack
    int         mw;       // wait cycles before data ack
    int         exp_lat;
    logic       exp_mem;
    logic       exp_we;
    logic       exp_md;
    logic       exp_ill;
    logic       exp_reg;
    logic       exp_csr;
    logic [1:0] exp_pc;
  } vec_t;

  logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111, 7'b1110011};

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", ctx, name, act, exp);
    end
  endtask

  function automatic int outs_or();
    return int'(mem_req | mem_we | mem_addr_s | ir_en | md_en | pc_en | (|pc_src) |
                reg_w_en | csr_w_en | illegal_op | retired);
  endfunction

  // Reference model: what one instruction should do, from the opcode rules.
  function automatic vec_t model(input logic [6:0] op, input logic rw, input logic cw,
                                 input logic [1:0] jmp, input logic br,
                                 input int fw, input int mw);
    vec_t v;
    logic legal = 1'b0;
    logic ld, st;
    foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
    ld = (op == 7'b0000011);
    st = (op == 7'b0100011);
    v.op = op; v.rw = rw; v.cw = cw; v.jmp = jmp; v.br = br; v.fw = fw; v.mw = mw;
    v.exp_ill = ~legal;
    v.exp_mem = legal & (ld | st);
    v.exp_we  = legal & st;
    v.exp_md  = legal & ld;
    v.exp_lat = 4 + fw + (v.exp_mem ? 1 + mw : 0);
    v.exp_reg = legal & rw;
    v.exp_csr = legal & cw;
    if (!legal)          v.exp_pc = 2'b00;
    else if (jmp != 0)   v.exp_pc = jmp;
    else if (br)         v.exp_pc = 2'b01;
    else                 v.exp_pc = 2'b00;
    return v;
  endfunction

  // ---------------- driver + monitor for one instruction ----------------
  // Starts on the cycle the DUT is expected to be in FETCH.
  task automatic run_instr(input vec_t v);
    logic [2:0] seen_q[$];
    logic [2:0] exp_q[$];
    int fl = v.fw, ml = v.mw, cyc = 0;
    int ir_n = 0, md_n = 0, ill_n = 0, stray = 0, hs_bad = 0, seq_bad = 0;
    logic done = 1'b0, first_ok = 1'b0, saw_mem = 1'b0, we_or = 1'b0;
    logic wb_reg = 1'b0, wb_csr = 1'b0, wb_pcen = 1'b0;
    logic [1:0] wb_pc = 2'b00;

    op_code = v.op; dec_reg_w = v.rw; dec_csr_w = v.cw; dec_jump = v.jmp; dec_branch = v.br;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (mem_req) begin
        if (mem_addr_s) begin
          if (ml == 0) mem_ack = 1'b1; else begin mem_ack = 1'b0; ml--; end
        end else begin
          if (fl == 0) mem_ack = 1'b1; else begin mem_ack = 1'b0; fl--; end
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));   // must be ignored
      end
      #1;
      if (cyc == 0) first_ok = (state == 3'd1) && mem_req && !mem_addr_s && !mem_we;
      seen_q.push_back(state);
      cyc++;
      ir_n  += int'(ir_en);
      md_n  += int'(md_en);
      ill_n += int'(illegal_op);
      if (state == 3'd4) begin
        saw_mem = 1'b1;
        we_or   = we_or | mem_we;
        if (!mem_req || !mem_addr_s || (mem_we != v.exp_we)) hs_bad++;
      end
      if (state == 3'd1 && (!mem_req || mem_addr_s || mem_we)) hs_bad++;
      if (state != 3'd5 && (reg_w_en || csr_w_en || pc_en || retired)) stray++;
      if (retired) begin
        wb_reg = reg_w_en; wb_csr = csr_w_en; wb_pcen = pc_en; wb_pc = pc_src;
        done = 1'b1;
      end
    end
    mem_ack = 1'b0;

    repeat (v.fw + 1) exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    if (v.exp_mem) repeat (v.mw + 1) exp_q.push_back(3'd4);
    exp_q.push_back(3'd5);
    foreach (exp_q[i]) if (i >= seen_q.size() || seen_q[i] != exp_q[i]) seq_bad++;

    check("retire_seen", int'(done), 1);
    check("fetch_first", int'(first_ok), 1);
    check("latency", cyc, v.exp_lat);
    check("state_seq", seq_bad, 0);
    check("mem_visit", int'(saw_mem), int'(v.exp_mem));
    check("mem_we", int'(we_or), int'(v.exp_we));
    check("ir_en_count", ir_n, 1);
    check("md_en_count", md_n, int'(v.exp_md));
    check("illegal_pulses", ill_n, int'(v.exp_ill));
    check("wb_reg_w_en", int'(wb_reg), int'(v.exp_reg));
    check("wb_csr_w_en", int'(wb_csr), int'(v.exp_csr));
    check("wb_pc_src", int'(wb_pc), int'(v.exp_pc));
    check("wb_pc_en", int'(wb_pcen), 1);
    check("strobe_outside_wb", stray, 0);
    check("port_attrs", hs_bad, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl [9];
    //            op           rw    cw    jmp    br    fw mw lat mem   we    md    ill   reg   csr   pc
    tbl[0] = '{7'b0110011, 1'b1, 1'b0, 2'b00, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00}; // ADD
    tbl[1] = '{7'b0000011, 1'b1, 1'b0, 2'b00, 1'b0, 0, 3, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00}; // LW slow
    tbl[2] = '{7'b0100011, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1, 6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // SW
    tbl[3] = '{7'b1100011, 1'b0, 1'b0, 2'b00, 1'b1, 0, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01}; // BEQ taken
    tbl[4] = '{7'b1100111, 1'b1, 1'b0, 2'b10, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10}; // JALR
    tbl[5] = '{7'b1111111, 1'b1, 1'b1, 2'b01, 1'b1, 0, 0, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}; // illegal
    tbl[6] = '{7'b1110011, 1'b1, 1'b1, 2'b00, 1'b0, 2, 0, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00}; // CSR slow fetch
    tbl[7] = '{7'b1101111, 1'b1, 1'b0, 2'b11, 1'b1, 0, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11}; // jump beats branch
    tbl[8] = '{7'b0000111, 1'b1, 1'b0, 2'b00, 1'b0, 1, 2, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}; // load-like illegal

    // Reset held for three cycles: everything quiet, state IDLE.
    ctx = "reset";
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_state", int'(state), 0);
      check("rst_outputs", outs_or(), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_state", int'(state), 0);

    foreach (tbl[i]) begin
      ctx = $sformatf("tbl%0d", i);
      run_instr(tbl[i]);
    end

    // Reset while a store sits unacked in MEM.
    ctx = "rst_in_mem";
    op_code = 7'b0100011; dec_reg_w = 1'b1; dec_csr_w = 1'b0; dec_jump = 2'b00; dec_branch = 1'b0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        mem_ack = mem_req && !mem_addr_s;
        #1;
        n++;
      end while (state != 3'd4 && n < 10);
    end
    check("reached_mem", int'(state), 4);
    check("store_req", int'(mem_req && mem_we && mem_addr_s), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_state", int'(state), 0);
    check("abort_req", int'(mem_req), 0);
    check("abort_strobes", int'(md_en | reg_w_en | retired), 0);
    ctx = "after_abort";
    run_instr(model(7'b0110011, 1'b1, 1'b0, 2'b00, 1'b0, 0, 0));

    // Randomised instructions against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic [6:0] op;
      if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 9)];
      else                          op = 7'($urandom_range(0, 127));
      ctx = $sformatf("rnd%0d_op%b", k, op);
      run_instr(model(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
